// File: rtl/demux_n.sv
// Clocked 4-phase one-hot demux: steers one bundled-data word to one of M output channels.
// Optional protocol checking is built only when DEMUX_ERR_EN is defined.
module demux_n #(
  parameter int unsigned N = 1,
  parameter int unsigned M = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r_i,
  output logic             a_i,
  input  logic [N-1:0]     d_i,
  input  logic [M-1:0]     ctl_i,
  output logic             actl_i,
  output logic [M-1:0]     r_o,
  input  logic [M-1:0]     a_o,
  output logic [M*N-1:0]   d_o,
  output logic             err
);

  localparam int unsigned SelW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StAck, StRtz} state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      data_q, data_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic [M-1:0]      r_o_q, r_o_d;
  logic              a_i_q, a_i_d;

  logic              ctl_onehot;
  logic [SelW-1:0]   ctl_enc;

  // OR-encoder: only meaningful when ctl_i is one-hot, so no priority is needed.
  always_comb begin
    ctl_onehot = (ctl_i != '0) && ((ctl_i & (ctl_i - M'(1))) == '0);
    ctl_enc    = '0;
    for (int k = 0; k < int'(M); k++) begin
      if (ctl_i[k]) ctl_enc = ctl_enc | SelW'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    r_o_d   = r_o_q;
    a_i_d   = a_i_q;
    unique case (state_q)
      StIdle: begin
        if (r_i && ctl_onehot) begin
          data_d  = d_i;
          sel_d   = ctl_enc;
          r_o_d   = ctl_i;
          state_d = StReq;
        end
      end
      StReq: begin
        if (a_o[sel_q]) begin
          a_i_d   = 1'b1;
          state_d = StAck;
        end
      end
      StAck: begin
        if (!r_i && (ctl_i == '0)) begin
          r_o_d   = '0;
          state_d = StRtz;
        end
      end
      StRtz: begin
        if (!a_o[sel_q]) begin
          a_i_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      sel_q   <= '0;
      r_o_q   <= '0;
      a_i_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      r_o_q   <= r_o_d;
      a_i_q   <= a_i_d;
    end
  end

  assign a_i    = a_i_q;
  assign actl_i = a_i_q;
  assign r_o    = r_o_q;
  assign d_o    = {M{data_q}};

`ifdef DEMUX_ERR_EN
  logic          err_q, err_d;
  logic [M-1:0]  sel_mask;
  logic          ctl_multi;

  always_comb begin
    sel_mask  = M'(1) << sel_q;
    ctl_multi = (ctl_i & (ctl_i - M'(1))) != '0;
    err_d     = err_q;
    unique case (state_q)
      StIdle: if (r_i && ctl_multi) err_d = 1'b1;
      StReq: begin
        if ((ctl_i != sel_mask) || (d_i != data_q) || ((a_o & ~sel_mask) != '0)) err_d = 1'b1;
      end
      StAck: if ((a_o & ~sel_mask) != '0) err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_demux_n.sv
// Scoreboard bench for demux_n: N=8/M=4 protocol scenarios plus an N=1/M=16 select sweep.
module tb_demux_n;

  localparam int unsigned N  = 8;
  localparam int unsigned M  = 4;
  localparam int unsigned N2 = 1;
  localparam int unsigned M2 = 16;

`ifdef DEMUX_ERR_EN
  localparam logic ErrOn = 1'b1;
`else
  localparam logic ErrOn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           r_i, a_i, actl_i, err;
  logic [N-1:0]   d_i;
  logic [M-1:0]   ctl_i, r_o, a_o;
  logic [M*N-1:0] d_o;

  logic             r2_i, a2_i, actl2_i, err2;
  logic [N2-1:0]    d2_i;
  logic [M2-1:0]    ctl2_i, r2_o, a2_o;
  logic [M2*N2-1:0] d2_o;

  demux_n #(.N(N), .M(M)) u_dut (
    .clk(clk), .rst(rst), .r_i(r_i), .a_i(a_i), .d_i(d_i), .ctl_i(ctl_i),
    .actl_i(actl_i), .r_o(r_o), .a_o(a_o), .d_o(d_o), .err(err)
  );

  demux_n #(.N(N2), .M(M2)) u_dut16 (
    .clk(clk), .rst(rst), .r_i(r2_i), .a_i(a2_i), .d_i(d2_i), .ctl_i(ctl2_i),
    .actl_i(actl2_i), .r_o(r2_o), .a_o(a2_o), .d_o(d2_o), .err(err2)
  );

  typedef struct {
    int         ch;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  logic       err_exp  = 1'b0;
  logic [7:0] word_exp = 8'h00;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-delay environment; lat reports edges from request to r_o rising.
  task automatic transfer(input int ch, input logic [7:0] data, output int lat);
    exp_t e;
    ctl_i = M'(1) << ch;
    d_i   = data;
    r_i   = 1'b1;
    sb.push_back('{ch, data});
    lat = 0;
    do begin
      tick();
      lat++;
    end while (r_o == '0 && lat < 10);
    e = sb.pop_front();
    word_exp = e.data;
    check_eq("req_onehot", r_o, M'(1) << e.ch);
    check_eq("req_lane", d_o[e.ch*N +: N], e.data);
    check_eq("req_a_i_low", a_i, 1'b0);
    a_o = M'(1) << e.ch;
    tick();
    check_eq("ack_a_i", {a_i, actl_i}, 2'b11);
    check_eq("ack_r_o_held", r_o, M'(1) << e.ch);
    r_i   = 1'b0;
    ctl_i = '0;
    tick();
    check_eq("rtz_r_o", r_o, '0);
    check_eq("rtz_a_i_held", a_i, 1'b1);
    a_o = '0;
    tick();
    check_eq("idle_a_i", {a_i, actl_i}, 2'b00);
    check_eq("xfer_err", err, err_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    rst = 1'b0; r_i = 1'b0; d_i = '0; ctl_i = '0; a_o = '0;
    r2_i = 1'b0; d2_i = '0; ctl2_i = '0; a2_o = '0;
    tick();
    tick();
    check_eq("rst_outputs", {a_i, actl_i, r_o, err}, '0);
    check_eq("rst_d_o", d_o, '0);
    rst = 1'b1;
    tick();

    // Single transfer with exact per-edge timing.
    transfer(2, 8'hA5, lat);
    check_eq("fwd_latency", lat, 1);

    // Back-to-back to channels 0 then 3.
    transfer(0, 8'h11, lat);
    transfer(3, 8'h22, lat);
    check_eq("b2b_lane3", d_o[3*N +: N], 8'h22);
    check_eq("b2b_all_lanes", d_o, {M{8'h22}});

    // Stray acknowledge on an unselected lane in REQ.
    ctl_i = 4'b0100; d_i = 8'h5C; r_i = 1'b1;
    tick();
    word_exp = 8'h5C;
    a_o = 4'b0010;
    tick();
    err_exp = ErrOn;
    check_eq("stray_hold_r_o", r_o, 4'b0100);
    check_eq("stray_hold_a_i", a_i, 1'b0);
    check_eq("stray_err", err, err_exp);
    a_o = 4'b0100;
    tick();
    check_eq("stray_then_ack", a_i, 1'b1);
    r_i = 1'b0; ctl_i = '0;
    tick();
    a_o = '0;
    tick();
    check_eq("stray_idle", {a_i, r_o}, '0);

    // Multi-hot select must be ignored.
    ctl_i = 4'b0110; d_i = 8'hEE; r_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("multihot_quiet", {a_i, r_o}, '0);
    end
    check_eq("multihot_d_o", d_o, {M{word_exp}});
    check_eq("multihot_err", err, err_exp);
    r_i = 1'b0; ctl_i = '0;
    tick();

    // Reset while in ACK.
    ctl_i = 4'b0001; d_i = 8'h5A; r_i = 1'b1;
    tick();
    a_o = 4'b0001;
    tick();
    check_eq("pre_rst_ack", a_i, 1'b1);
    rst = 1'b0; r_i = 1'b0; ctl_i = '0; a_o = '0;
    tick();
    err_exp  = 1'b0;
    word_exp = 8'h00;
    check_eq("midrst_outputs", {a_i, actl_i, r_o, err}, '0);
    check_eq("midrst_d_o", d_o, '0);
    rst = 1'b1;
    tick();
    transfer(1, 8'h3C, lat);
    check_eq("post_rst_latency", lat, 1);

    // M=16 select sweep.
    for (int k = 0; k < int'(M2); k++) begin
      exp_t e;
      ctl2_i = M2'(1) << k;
      d2_i   = N2'(k);
      r2_i   = 1'b1;
      sb.push_back('{k, 8'(k & 1)});
      tick();
      e = sb.pop_front();
      check_eq("sweep_r_o", r2_o, M2'(1) << e.ch);
      check_eq("sweep_d_o", d2_o, {M2{e.data[0]}});
      a2_o = M2'(1) << e.ch;
      tick();
      check_eq("sweep_ack", a2_i, 1'b1);
      r2_i = 1'b0; ctl2_i = '0;
      tick();
      a2_o = '0;
      tick();
      check_eq("sweep_idle", {a2_i, r2_o}, '0);
    end
    check_eq("sweep_err", err2, 1'b0);
    check_eq("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_n.md
# demux_n

Clocked, parametrised successor to the two-way C-element demux. It accepts one bundled-data word on a 4-phase input channel, steers it to exactly one of M output channels selected by an M-rail one-hot control channel, and completes full return-to-zero on both sides before accepting the next word. It sits in the conditional-flow library, where synchronous islands need steering with the same handshake semantics as the asynchronous fabric.

## Interface
Parameters:
- N, 1: data width in bits.
- M, 2: number of output channels, 2..16.

Ports:
- clk  input  1  clock; all inputs are sampled and all outputs change on the rising edge.
- rst  input  1  reset, synchronous and active-low (rst=0 resets on the next rising clk edge).
- r_i  input  1  input request (4-phase).
- a_i  output  1  input acknowledge.
- d_i  input  N  input data, bundled with r_i.
- ctl_i  input  M  one-hot select; bit k selects output channel k. All-zero is the spacer.
- actl_i  output  1  control acknowledge; always equal to a_i.
- r_o  output  M  output requests, at most one bit high at any time.
- a_o  input  M  output acknowledges.
- d_o  output  M*N  output data; lane k is d_o[k*N +: N]. All lanes carry the captured word.
- err  output  1  sticky protocol-error flag (see Configuration).

## Operation
- All outputs are registered. After reset: a_i=0, actl_i=0, r_o=0, d_o=0, err=0, data register=0, sel=0, state=IDLE.
- IDLE: wait for r_i=1 with ctl_i exactly one-hot. Then capture d_i into the data register and the index of the set bit into sel, and go to REQ. If r_i=1 while ctl_i is zero or has more than one bit set, stay in IDLE and capture nothing.
- REQ: r_o[sel]=1. When a_o[sel]=1, set a_i and actl_i to 1 and go to ACK.
- ACK: wait for r_i=0 and ctl_i=0. Then clear r_o[sel] and go to RTZ.
- RTZ: wait for a_o[sel]=0. Then clear a_i and actl_i and go to IDLE.
- The d_o lanes hold the captured word from the capture edge until the next capture. They do not change during REQ, ACK or RTZ.
- a_o bits for unselected channels are ignored in every state. A stray acknowledge never advances the FSM.
- Arithmetic: sel is clog2(M) bits wide. A one-hot check plus an encoder produces it, with no priority fallback.

## Timing
- Edge t samples r_i=1 with valid ctl_i. At edge t+1, r_o[sel] goes high and d_o is valid. Forward latency is 1 cycle.
- Edge u samples a_o[sel]=1 in REQ. At edge u+1, a_i and actl_i go high.
- Edge v samples r_i=0 and ctl_i=0 in ACK. At edge v+1, r_o[sel] goes low.
- Edge w samples a_o[sel]=0 in RTZ. At edge w+1, a_i goes low.
- Minimum full transfer is 4 cycles when the environment responds in zero cycles.
- Simultaneous events: if a_o[sel] rises in the same cycle as r_i falls, only the REQ->ACK transition is taken. Each edge advances at most one state.
- A new r_i=1 cannot be accepted until IDLE is reached. In IDLE, a new request is accepted on the same edge that samples it, so RTZ->IDLE->REQ takes 2 edges.
- Reset mid-operation: from any state, rst=0 forces all outputs to their reset values at the next edge. The environment must also return to zero.

## Configuration
- DEMUX_ERR_EN.
- Defined: err is set, and stays set until reset, when any of the following occurs:
  - In IDLE, r_i=1 with ctl_i having more than one bit set.
  - In REQ, ctl_i or d_i differs from its captured value.
  - In REQ or ACK, any unselected a_o bit is 1.
  Detection does not alter the FSM.
- Undefined: err is tied to 0 and no checking logic is built.

## Test plan
- N=8, M=4: ctl_i=4'b0100, d_i=8'hA5, r_i=1 at edge 0, then a zero-delay environment. Expect r_o=4'b0100 and d_o lane 2=8'hA5 at edge 1, a_i=1 at edge 2, r_o=0 at edge 3, a_i=0 at edge 4.
- Back-to-back transfers to channels 0 then 3, with data 8'h11 then 8'h22. Expect each handshake to complete, no r_o overlap, and d_o lane 3=8'h22 after the second capture.
- Raise a_o[1] while sel=2 in REQ. Expect the FSM to hold in REQ and, with DEMUX_ERR_EN, err=1 one edge later.
- ctl_i=4'b0110 with r_i=1 for 5 cycles. Expect a_i=0, r_o=0 and d_o unchanged; err=1 only when DEMUX_ERR_EN is defined.
- Assert rst=0 for 1 cycle while in ACK. Expect a_i=0, r_o=0, d_o=0 at the next edge, and a clean following transfer after rst=1.
- M=16, N=1: sweep all 16 selects. Expect exactly r_o[k] high for select k.
